sd_spi_responder: RTL and testbench
===================================

// Module: sd_spi_responder
// PURPOSE
//  SPI-mode SD-card responder: the card end of the SD/SPI link that the autotest SPI master drives.
//  Decodes commands, returns R1/R3/R7 responses, serves single-block reads and accepts single-block writes.
//  Block data lives in an external byte-wide RAM. Used for card-less FPGA loopback and sim benches of the autotest flow.
// PARAMETERS
//  ADDR_W       8    block-address width; number of blocks = 2**ADDR_W, 512 B each
//  NCR_BYTES    1    0xFF filler bytes between command CRC byte and response (1..8)
//  BUSY_BYTES   2    0x00 busy bytes after a write data-response token (1..15)
//  SYNC_STAGES  2    synchroniser depth on cs/sclk/mosi
// PORTS
//  clk        in   1         system clock; >= 8x sclk
//  rst        in   1         asynchronous reset, active-high
//  cs         in   1         chip select, active-low, async to clk
//  sclk       in   1         SPI clock, mode 0, async to clk
//  mosi       in   1         master-to-card data
//  miso       out  1         card-to-master data; always driven, never tristated
//  mem_addr   out  ADDR_W+9  {block, byte offset}
//  mem_we     out  1         one-cycle write strobe
//  mem_wdata  out  8         write byte
//  mem_rdata  in   8         read byte; valid 1 clk after mem_addr changes
//  card_idle  out  1         R1 idle flag
//  last_cmd   out  6         index of last accepted command
// BEHAVIOUR
//  Reset: miso=1, mem_we=0, mem_addr=0, mem_wdata=0, card_idle=1, last_cmd=0, FSM=CMD_WAIT.
//  Bit layer: sample mosi on synchronised sclk rising edge. Load next miso bit on falling edge, MSB first.
//    Default TX byte is 0xFF.
//  cs high: bit counter cleared, FSM forced to CMD_WAIT, miso=1. card_idle and last_cmd kept.
//    Applies mid-transfer; a partial write leaves already-written bytes in RAM.
//  Command frame: 6 bytes. First byte must match 01xxxxxx, otherwise discarded.
//    The next 5 bytes are arg[31:0] and CRC. CRC is ignored.
//  After the frame: NCR_BYTES of 0xFF, then the response:
//   CMD0      -> R1 0x01; card_idle=1
//   CMD8      -> R7 = R1 then 00 00 01 arg[7:0]
//   CMD55     -> R1; arms ACMD flag for the next command only
//   ACMD41    -> R1 0x00; card_idle=0. Without the armed flag -> R1 0x04|idle.
//   CMD58     -> R3 = R1 then C0 FF 80 00
//   CMD17/24  -> R1 0x04|idle if card_idle=1. R1 0x40 if arg >= 2**ADDR_W. Else R1 0x00 and start data phase.
//   other     -> R1 0x04|idle (illegal command)
//  Read (CMD17): one 0xFF gap byte, token 0xFE, 512 data bytes from mem_addr={arg,0..511}, CRC FF FF, then CMD_WAIT.
//    The next byte is prefetched at each byte boundary.
//  Write (CMD24): skip 0xFF bytes until 0xFE. Any other byte aborts to CMD_WAIT.
//    Then 512 bytes: one mem_we pulse per byte, in the clk after the 8th bit. Offset wraps 511->end of data phase.
//    Then 2 CRC bytes ignored, data-response 0x05, BUSY_BYTES of 0x00, then CMD_WAIT.
//  A new command byte arriving during any response or data phase is ignored.
//  FSM: CMD_WAIT, CMD_COLLECT, NCR, RESP, RESP_TAIL, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
//  last_cmd updates when a command frame completes.
// STRUCTURE
//  sd_spi_pkg:
//    CMD_* indices; R1 bits IDLE=0x01, ILLEGAL=0x04, PARAM=0x40
//    TOKEN_START=8'hFE, DATA_ACCEPT=8'h05, OCR=32'hC0FF8000
//    state_t enum
//  Sub-module spi_slave_byte:
//    synchronisers, edge detect, RX shift register with byte_valid pulse, TX shift register with load/ready.
//  Top holds command decode, FSM and memory addressing.
// TESTING
//  CMD0 40 00 00 00 00 95 -> one FF, then R1 0x01; card_idle=1; last_cmd=0.
//  CMD8 arg 0x1AA -> FF, 01 00 00 01 AA.
//  CMD55 then ACMD41 -> 01, 00; card_idle=0. ACMD41 with no CMD55 -> 05.
//  RAM preset to offset-pattern, CMD17 arg 3 -> 00, FF, FE, 512 bytes matching block 3, FF FF.
//  CMD24 arg 2: FE, 0x00..0xFF x2, CRC -> 00, 05, 00 00; RAM block 2 correct; exactly 512 mem_we pulses.
//  CMD17 arg 256 (ADDR_W=8) -> 0x40, no token. cs high mid-read then CMD0 -> clean 0x01.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SPI-mode SD-card responder.
package sd_spi_pkg;

  // Command indices the responder understands
  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  // R1 flag bits
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] R1_PARAM   = 8'h40;

  // Tokens and fixed response payloads
  localparam logic [7:0]  TOKEN_START = 8'hFE;
  localparam logic [7:0]  DATA_ACCEPT = 8'h05;
  localparam logic [7:0]  FILL_BYTE   = 8'hFF;
  localparam logic [31:0] OCR         = 32'hC0FF8000;

  typedef enum logic [3:0] {
    CMD_WAIT, CMD_COLLECT, NCR, RESP, RESP_TAIL,
    RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;

  // What follows the R1 byte of a response
  typedef enum logic [2:0] {RESP_R1, RESP_R7, RESP_R3, RESP_RD, RESP_WR} resp_t;

  // R7 trailer: voltage accepted (2.7-3.6 V) and echoed check pattern
  function automatic logic [31:0] r7_tail(input logic [7:0] check);
    return {16'h0000, 8'h01, check};
  endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte layer: synchronises cs/sclk/mosi into clk, assembles
// received bytes and shifts out the next transmit byte MSB first.
module spi_slave_byte #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic [7:0] tx_byte,
  output logic       miso,
  output logic       cs_active,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic       sclk_prev;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;

  logic sclk_s, mosi_s, sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_active = ~cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign miso      = tx_shift[7];

  // Bring the asynchronous SPI pins into the clk domain.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours (shift chains stay intact).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  // Sample on sclk rise, advance miso on sclk fall; load a fresh byte at the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev  <= 1'b0;
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      tx_shift   <= 8'hFF;
    end else begin
      sclk_prev  <= sclk_s;
      byte_valid <= 1'b0;
      if (!cs_active) begin
        bit_cnt  <= 3'd0;
        tx_shift <= 8'hFF;
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            rx_byte    <= {rx_shift[6:0], mosi_s};
          end
        end
        if (sclk_fall) begin
          // bit_cnt wrapped to zero means the falling edge after the 8th bit
          tx_shift <= (bit_cnt == 3'd0) ? tx_byte : {tx_shift[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD-card responder: command decode, response sequencing and
// single-block read/write against an external byte-wide RAM.
module sd_spi_responder import sd_spi_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int NCR_BYTES   = 1,
  parameter int BUSY_BYTES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W+8:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              card_idle,
  output logic [5:0]        last_cmd
);

  localparam logic [3:0] NCR_LAST  = 4'(NCR_BYTES - 1);
  localparam logic [3:0] BUSY_LAST = 4'(BUSY_BYTES - 1);

  logic       cs_active, byte_valid;
  logic [7:0] rx_byte, tx_data;

  state_t      state;
  resp_t       kind;
  logic [3:0]  cnt;
  logic [8:0]  byte_cnt;
  logic [5:0]  cmd_idx;
  logic [31:0] arg, tail;
  logic [7:0]  r1;
  logic        acmd_armed;

  logic [7:0] idle_r1, dec_r1;
  resp_t      dec_kind;
  logic       dec_idle;

  spi_slave_byte #(.SYNC_STAGES(SYNC_STAGES)) u_byte (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .tx_byte   (tx_data),
    .miso      (miso),
    .cs_active (cs_active),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte)
  );

  assign idle_r1 = card_idle ? R1_IDLE : 8'h00;

  // Decode the collected frame into R1, response shape and new idle state.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    dec_r1   = R1_ILLEGAL | idle_r1;
    dec_kind = RESP_R1;
    dec_idle = card_idle;
    case (cmd_idx)
      CMD0: begin
        dec_r1   = R1_IDLE;
        dec_idle = 1'b1;
      end
      CMD8: begin
        dec_r1   = idle_r1;
        dec_kind = RESP_R7;
      end
      CMD55: dec_r1 = idle_r1;
      CMD41: begin
        if (acmd_armed) begin
          dec_r1   = 8'h00;
          dec_idle = 1'b0;
        end
      end
      CMD58: begin
        dec_r1   = idle_r1;
        dec_kind = RESP_R3;
      end
      CMD17, CMD24: begin
        if (card_idle) begin
          dec_r1 = R1_ILLEGAL | idle_r1;
        end else if ((arg >> ADDR_W) != 32'd0) begin
          dec_r1 = R1_PARAM;
        end else begin
          dec_r1   = 8'h00;
          dec_kind = (cmd_idx == CMD17) ? RESP_RD : RESP_WR;
        end
      end
      default: ;
    endcase
  end

  // Byte-level protocol FSM: each received byte decides the next byte to send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CMD_WAIT;
      kind       <= RESP_R1;
      cnt        <= 4'd0;
      byte_cnt   <= 9'd0;
      cmd_idx    <= 6'd0;
      arg        <= 32'd0;
      tail       <= 32'd0;
      r1         <= FILL_BYTE;
      acmd_armed <= 1'b0;
      tx_data    <= FILL_BYTE;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h00;
      card_idle  <= 1'b1;
      last_cmd   <= 6'd0;
    end else begin
      mem_we <= 1'b0;
      if (!cs_active) begin
        state   <= CMD_WAIT;
        tx_data <= FILL_BYTE;
      end else if (byte_valid) begin
        tx_data <= FILL_BYTE;
        case (state)
          CMD_WAIT: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd_idx <= rx_byte[5:0];
              cnt     <= 4'd0;
              state   <= CMD_COLLECT;
            end
          end
          CMD_COLLECT: begin
            if (cnt == 4'd4) begin
              // CRC byte closes the frame; it is not checked
              last_cmd   <= cmd_idx;
              card_idle  <= dec_idle;
              acmd_armed <= (cmd_idx == CMD55);
              r1         <= dec_r1;
              kind       <= dec_kind;
              tail       <= (dec_kind == RESP_R7) ? r7_tail(arg[7:0]) : OCR;
              if (dec_kind == RESP_RD || dec_kind == RESP_WR)
                mem_addr <= {arg[ADDR_W-1:0], 9'd0};
              cnt   <= 4'd0;
              state <= NCR;
            end else begin
              arg <= {arg[23:0], rx_byte};
              cnt <= cnt + 4'd1;
            end
          end
          NCR: begin
            if (cnt == NCR_LAST) begin
              tx_data <= r1;
              state   <= RESP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          RESP: begin
            cnt <= 4'd0;
            case (kind)
              RESP_R7, RESP_R3: begin
                tx_data <= tail[31:24];
                tail    <= tail << 8;
                state   <= RESP_TAIL;
              end
              RESP_RD: state <= RD_GAP;
              RESP_WR: state <= WR_TOKEN;
              default: state <= CMD_WAIT;
            endcase
          end
          RESP_TAIL: begin
            if (cnt == 4'd3) begin
              state <= CMD_WAIT;
            end else begin
              tx_data <= tail[31:24];
              tail    <= tail << 8;
              cnt     <= cnt + 4'd1;
            end
          end
          RD_GAP: begin
            tx_data <= TOKEN_START;
            state   <= RD_TOKEN;
          end
          RD_TOKEN: begin
            // mem_rdata already holds offset 0; prefetch offset 1
            tx_data       <= mem_rdata;
            mem_addr[8:0] <= mem_addr[8:0] + 9'd1;
            byte_cnt      <= 9'd0;
            state         <= RD_DATA;
          end
          RD_DATA: begin
            if (byte_cnt == 9'd511) begin
              cnt   <= 4'd0;
              state <= RD_CRC;
            end else begin
              tx_data       <= mem_rdata;
              mem_addr[8:0] <= mem_addr[8:0] + 9'd1;
              byte_cnt      <= byte_cnt + 9'd1;
            end
          end
          RD_CRC: begin
            if (cnt == 4'd1) state <= CMD_WAIT;
            else             cnt   <= cnt + 4'd1;
          end
          WR_TOKEN: begin
            if (rx_byte == TOKEN_START) begin
              byte_cnt <= 9'd0;
              state    <= WR_DATA;
            end else if (rx_byte != FILL_BYTE) begin
              state <= CMD_WAIT;
            end
          end
          WR_DATA: begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_byte;
            mem_addr  <= {mem_addr[ADDR_W+8:9], byte_cnt};
            byte_cnt  <= byte_cnt + 9'd1;
            if (byte_cnt == 9'd511) begin
              cnt   <= 4'd0;
              state <= WR_CRC;
            end
          end
          WR_CRC: begin
            if (cnt == 4'd1) begin
              tx_data <= DATA_ACCEPT;
              state   <= WR_RESP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          WR_RESP: begin
            tx_data <= 8'h00;
            cnt     <= 4'd0;
            state   <= WR_BUSY;
          end
          WR_BUSY: begin
            if (cnt == BUSY_LAST) begin
              state <= CMD_WAIT;
            end else begin
              tx_data <= 8'h00;
              cnt     <= cnt + 4'd1;
            end
          end
          default: state <= CMD_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder acting as the SPI master plus a RAM model.
module tb_sd_spi_responder;

  localparam int ADDR_W = 8;
  localparam int MEM_SZ = 1 << (ADDR_W + 9);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cs = 1'b1;
  logic              sclk = 1'b0;
  logic              mosi = 1'b1;
  logic              miso;
  logic [ADDR_W+8:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              card_idle;
  logic [5:0]        last_cmd;

  int n_checks = 0;
  int n_fails  = 0;
  int we_count = 0;

  logic [7:0] ram [0:MEM_SZ-1];
  logic [7:0] rsp [0:599];

  sd_spi_responder #(.ADDR_W(ADDR_W), .NCR_BYTES(1), .BUSY_BYTES(2), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .card_idle(card_idle),
    .last_cmd (last_cmd)
  );

  always #5 clk = ~clk;

  // Preset content: depends on offset and block so blocks are distinguishable
  function automatic logic [7:0] pattern(input logic [ADDR_W+8:0] a);
    return a[7:0] + {a[8], 7'b0} + 8'(a[ADDR_W+8:9]);
  endfunction

  // RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_SZ; i++) ram[i] <= pattern((ADDR_W+9)'(i));
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) if (mem_we) we_count <= we_count + 1;

  // One mode-0 byte: drive mosi, sample miso at the rising edge
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #40 sclk = 1'b1;
      rx[i] = miso;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80 cs = 1'b1;
    mosi = 1'b1;
    #160;
  endtask

  // Send a 6-byte frame then clock n_rsp filler bytes into rsp[]
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc, input int n_rsp);
    logic [7:0] d;
    spi_byte({2'b01, idx}, d);
    spi_byte(arg[31:24], d);
    spi_byte(arg[23:16], d);
    spi_byte(arg[15:8], d);
    spi_byte(arg[7:0], d);
    spi_byte(crc, d);
    for (int i = 0; i < n_rsp; i++) begin
      spi_byte(8'hFF, d);
      rsp[i] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #28;
    n_checks++;
    if (miso !== 1'b1 || mem_we !== 1'b0) begin
      n_fails++; $display("FAIL reset_miso_we: got %b%b, expected 10", miso, mem_we);
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== 8'h00) begin
      n_fails++; $display("FAIL reset_mem: got addr %h wdata %h, expected 0 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (card_idle !== 1'b1 || last_cmd !== 6'd0) begin
      n_fails++; $display("FAIL reset_status: got idle %b last %0d, expected 1 0", card_idle, last_cmd);
    end
    #10 rst = 1'b0;
    #40;
  endtask

  task automatic test_cmd0();
    cs_low();
    send_cmd(6'd0, 32'd0, 8'h95, 3);
    cs_high();
    n_checks++;
    if (rsp[0] !== 8'hFF || rsp[1] !== 8'h01 || rsp[2] !== 8'hFF) begin
      n_fails++; $display("FAIL cmd0_resp: got %h %h %h, expected ff 01 ff", rsp[0], rsp[1], rsp[2]);
    end
    n_checks++;
    if (card_idle !== 1'b1 || last_cmd !== 6'd0) begin
      n_fails++; $display("FAIL cmd0_status: got idle %b last %0d, expected 1 0", card_idle, last_cmd);
    end
  endtask

  task automatic test_cmd8();
    logic [7:0] exp_b [0:6] = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hFF};
    cs_low();
    send_cmd(6'd8, 32'h0000_01AA, 8'h87, 7);
    cs_high();
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (rsp[i] !== exp_b[i]) begin
        n_fails++; $display("FAIL cmd8_byte%0d: got %h, expected %h", i, rsp[i], exp_b[i]);
      end
    end
    n_checks++;
    if (last_cmd !== 6'd8) begin
      n_fails++; $display("FAIL cmd8_last: got %0d, expected 8", last_cmd);
    end
  endtask

  task automatic test_not_ready();
    cs_low();
    send_cmd(6'd41, 32'h4000_0000, 8'h77, 2);
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h05 || card_idle !== 1'b1) begin
      n_fails++; $display("FAIL acmd41_unarmed: got %h idle %b, expected 05 1", rsp[1], card_idle);
    end
    cs_low();
    send_cmd(6'd17, 32'd3, 8'h01, 4);
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h05 || rsp[2] !== 8'hFF || rsp[3] !== 8'hFF) begin
      n_fails++; $display("FAIL cmd17_idle: got %h %h %h, expected 05 ff ff", rsp[1], rsp[2], rsp[3]);
    end
    cs_low();
    send_cmd(6'd9, 32'd0, 8'h01, 2);
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h05 || last_cmd !== 6'd9) begin
      n_fails++; $display("FAIL illegal_cmd: got %h last %0d, expected 05 9", rsp[1], last_cmd);
    end
  endtask

  task automatic test_acmd41();
    cs_low();
    send_cmd(6'd55, 32'd0, 8'h65, 2);
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h01) begin
      n_fails++; $display("FAIL cmd55_r1: got %h, expected 01", rsp[1]);
    end
    cs_low();
    send_cmd(6'd41, 32'h4000_0000, 8'h77, 3);
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h00 || rsp[2] !== 8'hFF) begin
      n_fails++; $display("FAIL acmd41_r1: got %h %h, expected 00 ff", rsp[1], rsp[2]);
    end
    n_checks++;
    if (card_idle !== 1'b0 || last_cmd !== 6'd41) begin
      n_fails++; $display("FAIL acmd41_status: got idle %b last %0d, expected 0 41", card_idle, last_cmd);
    end
  endtask

  // Garbage bytes that do not match 01xxxxxx precede a CMD58 and must be dropped
  task automatic test_cmd58();
    logic [7:0] d;
    logic [7:0] exp_b [0:6] = '{8'hFF, 8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00, 8'hFF};
    cs_low();
    spi_byte(8'h3F, d);
    spi_byte(8'h80, d);
    send_cmd(6'd58, 32'd0, 8'hFD, 7);
    cs_high();
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (rsp[i] !== exp_b[i]) begin
        n_fails++; $display("FAIL cmd58_byte%0d: got %h, expected %h", i, rsp[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_read();
    int bad = 0;
    int first_bad = -1;
    int we_before = we_count;
    logic [7:0] exp_d;
    cs_low();
    send_cmd(6'd17, 32'd3, 8'h01, 519);
    cs_high();
    n_checks++;
    if (rsp[0] !== 8'hFF || rsp[1] !== 8'h00 || rsp[2] !== 8'hFF || rsp[3] !== 8'hFE) begin
      n_fails++; $display("FAIL read_head: got %h %h %h %h, expected ff 00 ff fe", rsp[0], rsp[1], rsp[2], rsp[3]);
    end
    for (int i = 0; i < 512; i++) begin
      exp_d = pattern({8'd3, 9'(i)});
      if (rsp[4+i] !== exp_d) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL read_data: %0d bad bytes, first at %0d got %h, expected %h",
               bad, first_bad, rsp[4+first_bad], pattern({8'd3, 9'(first_bad)}));
    end
    n_checks++;
    if (rsp[516] !== 8'hFF || rsp[517] !== 8'hFF || rsp[518] !== 8'hFF) begin
      n_fails++; $display("FAIL read_tail: got %h %h %h, expected ff ff ff", rsp[516], rsp[517], rsp[518]);
    end
    n_checks++;
    if (we_count != we_before) begin
      n_fails++; $display("FAIL read_no_write: got %0d strobes, expected 0", we_count - we_before);
    end
  endtask

  task automatic test_range();
    cs_low();
    send_cmd(6'd17, 32'd256, 8'h01, 6);
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h40) begin
      n_fails++; $display("FAIL range_r1: got %h, expected 40", rsp[1]);
    end
    n_checks++;
    if (rsp[2] !== 8'hFF || rsp[3] !== 8'hFF || rsp[4] !== 8'hFF || rsp[5] !== 8'hFF) begin
      n_fails++; $display("FAIL range_no_token: got %h %h %h %h, expected ff ff ff ff", rsp[2], rsp[3], rsp[4], rsp[5]);
    end
  endtask

  task automatic test_write();
    logic [7:0] d;
    logic [7:0] tail_b [0:3];
    int bad = 0;
    int first_bad = -1;
    int we_before = we_count;
    cs_low();
    send_cmd(6'd24, 32'd2, 8'h01, 2);
    spi_byte(8'hFE, d);
    for (int i = 0; i < 512; i++) spi_byte(8'(i), d);
    spi_byte(8'hAB, d);
    spi_byte(8'hCD, d);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'hFF, d);
      tail_b[i] = d;
    end
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h00) begin
      n_fails++; $display("FAIL write_r1: got %h, expected 00", rsp[1]);
    end
    n_checks++;
    if (tail_b[0] !== 8'h05 || tail_b[1] !== 8'h00 || tail_b[2] !== 8'h00 || tail_b[3] !== 8'hFF) begin
      n_fails++; $display("FAIL write_resp: got %h %h %h %h, expected 05 00 00 ff",
                          tail_b[0], tail_b[1], tail_b[2], tail_b[3]);
    end
    n_checks++;
    if (we_count - we_before != 512) begin
      n_fails++; $display("FAIL write_strobes: got %0d, expected 512", we_count - we_before);
    end
    for (int i = 0; i < 512; i++) begin
      if (ram[{8'd2, 9'(i)}] !== 8'(i)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++; $display("FAIL write_data: %0d bad bytes, first at %0d got %h, expected %h",
                          bad, first_bad, ram[{8'd2, 9'(first_bad)}], 8'(first_bad));
    end
    n_checks++;
    if (ram[{8'd1, 9'd511}] !== pattern({8'd1, 9'd511}) || ram[{8'd3, 9'd0}] !== pattern({8'd3, 9'd0})) begin
      n_fails++; $display("FAIL write_neighbours: got %h %h, expected %h %h",
                          ram[{8'd1, 9'd511}], ram[{8'd3, 9'd0}], pattern({8'd1, 9'd511}), pattern({8'd3, 9'd0}));
    end
  endtask

  // A non-FF, non-token byte while waiting for the start token aborts the write
  task automatic test_write_abort();
    logic [7:0] d;
    int we_before = we_count;
    cs_low();
    send_cmd(6'd24, 32'd4, 8'h01, 2);
    spi_byte(8'hFF, d);
    spi_byte(8'h55, d);
    send_cmd(6'd58, 32'd0, 8'hFD, 3);
    cs_high();
    n_checks++;
    if (rsp[1] !== 8'h00 || rsp[2] !== 8'hC0 || we_count != we_before) begin
      n_fails++; $display("FAIL write_abort: got %h %h strobes %0d, expected 00 c0 0",
                          rsp[1], rsp[2], we_count - we_before);
    end
  endtask

  task automatic test_cs_abort();
    cs_low();
    send_cmd(6'd17, 32'd3, 8'h01, 10);
    cs_high();
    cs_low();
    send_cmd(6'd0, 32'd0, 8'h95, 3);
    cs_high();
    n_checks++;
    if (rsp[0] !== 8'hFF || rsp[1] !== 8'h01 || rsp[2] !== 8'hFF) begin
      n_fails++; $display("FAIL cs_abort_cmd0: got %h %h %h, expected ff 01 ff", rsp[0], rsp[1], rsp[2]);
    end
    n_checks++;
    if (card_idle !== 1'b1 || last_cmd !== 6'd0 || miso !== 1'b1) begin
      n_fails++; $display("FAIL cs_abort_status: got idle %b last %0d miso %b, expected 1 0 1",
                          card_idle, last_cmd, miso);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_not_ready();
    test_acmd41();
    test_cmd58();
    test_read();
    test_range();
    test_write();
    test_write_abort();
    test_cs_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
